// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types and responder FSM encoding.
// Pure type/constant package; no logic, no latency, no backpressure.
package dbus_sram_responder_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    DR_IDLE,
    DR_WAIT,
    DR_RESP
  } dresp_state_t;

  localparam int DBUS_LAT_MAX = 15;

  // Wide enough for DBUS_LAT_MAX-1 plus up to 3 random stall cycles.
  localparam int DBUS_CNT_W = 5;

endpackage

// File: rtl/dbus_sram_array.sv
// Single-port 64-bit SRAM, byte-lane writes, registered read (read data valid the cycle after rd_en).
// Read data holds between reads; no backpressure, the caller schedules accesses.
module dbus_sram_array #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic                     rd_en,
  input  logic                     rd_zero,
  input  logic [7:0]               wr_be,
  input  logic [63:0]              wr_data,
  output logic [63:0]              rd_data
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Contents are never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= rd_zero ? 64'h0 : mem[idx];
    end
  end

endmodule

// File: rtl/dbus_sram_responder.sv
// Data-bus SRAM responder: one request at a time, data_ok LATENCY cycles after acceptance, all outputs registered.
// Requester holds dreq until data_ok; optional DBUS_RESP_STALL_EN adds 0..3 LFSR-driven wait cycles.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int          DEPTH   = 1024,
  parameter logic [63:0] BASE    = 64'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int IW = $clog2(DEPTH);
  localparam int LAT_EFF = (LATENCY < 1) ? 1 :
                           (LATENCY > DBUS_LAT_MAX) ? DBUS_LAT_MAX : LATENCY;
  localparam logic [DBUS_CNT_W-1:0] LAT_M1 = DBUS_CNT_W'(LAT_EFF - 1);
  localparam logic [60:0] DEPTH_W = 61'(DEPTH);

  dresp_state_t          state, state_next;
  logic [DBUS_CNT_W-1:0] cnt, cnt_next, load_val;
  logic                  accept;

  logic [63:0]   live_off;
  logic [IW-1:0] live_idx;
  logic          live_in_range;

  logic [IW-1:0] idx_q;
  logic [7:0]    strobe_q;
  logic [63:0]   data_q;
  logic          in_range_q;

  logic          addr_ok_q, data_ok_q;
  logic [IW-1:0] arr_idx;
  logic          arr_rd_en, arr_rd_zero;
  logic [7:0]    arr_be;
  logic [63:0]   arr_rdata;

  logic          unused_bits;

  assign live_off      = dreq.addr - BASE;
  assign live_idx      = live_off[3 +: IW];
  assign live_in_range = (dreq.addr >= BASE) && (live_off[63:3] < DEPTH_W);
  assign unused_bits   = ^{dreq.size, live_off[2:0]};

`ifdef DBUS_RESP_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign load_val = LAT_M1 + DBUS_CNT_W'(lfsr[1:0]);
`else
  assign load_val = LAT_M1;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    unique case (state)
      DR_IDLE: begin
        if (dreq.valid) begin
          accept     = 1'b1;
          cnt_next   = load_val;
          state_next = (load_val == '0) ? DR_RESP : DR_WAIT;
        end
      end
      DR_WAIT: begin
        cnt_next = cnt - 1'b1;
        if (cnt <= DBUS_CNT_W'(1)) state_next = DR_RESP;
      end
      DR_RESP: state_next = DR_IDLE;
      default: state_next = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= DR_IDLE;
      cnt       <= '0;
      addr_ok_q <= 1'b0;
      data_ok_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      addr_ok_q <= (state_next == DR_RESP);
      data_ok_q <= (state_next == DR_RESP);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q      <= live_idx;
      strobe_q   <= dreq.strobe;
      data_q     <= dreq.data;
      in_range_q <= live_in_range;
    end
  end

  // With LATENCY==1 the read is issued on the accepting edge, so it must see the live request.
  assign arr_idx     = (state == DR_IDLE) ? live_idx : idx_q;
  assign arr_rd_zero = (state == DR_IDLE) ? !live_in_range : !in_range_q;
  assign arr_rd_en   = (state_next == DR_RESP);
  assign arr_be      = (state == DR_RESP && in_range_q && !reset) ? strobe_q : 8'h00;

  dbus_sram_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk    (clk),
    .reset  (reset),
    .idx    (arr_idx),
    .rd_en  (arr_rd_en),
    .rd_zero(arr_rd_zero),
    .wr_be  (arr_be),
    .wr_data(data_q),
    .rd_data(arr_rdata)
  );

  assign dresp = '{addr_ok: addr_ok_q, data_ok: data_ok_q, data: arr_rdata};

endmodule
